// File: rtl/mac_tree_acc.sv
// Signed dot-product engine: per-lane products, registered adder tree, group accumulator.
// Define SATURATE_EN to clamp the accumulator instead of wrapping.
module mac_tree_acc #(
    parameter int bw      = 8,
    parameter int pr      = 8,
    parameter int bw_psum = 2*bw+6
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    input  logic                 in_first,
    input  logic                 in_last,
    input  logic [pr*bw-1:0]     a,
    input  logic [pr*bw-1:0]     b,
    output logic [bw_psum-1:0]   out,
    output logic                 out_valid
);

    localparam int lv = $clog2(pr);

    logic signed [2*bw-1:0]    prod_q   [pr];
    logic signed [bw_psum-1:0] node_q   [1:pr-1];
    logic signed [bw_psum-1:0] node_all [1:2*pr-1];
    logic [lv:0]               v_q, f_q, l_q;
    logic signed [bw_psum-1:0] acc_q, acc_base, acc_sum, acc_nxt, tree;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < pr; i++) prod_q[i] <= '0;
        end else begin
            for (int i = 0; i < pr; i++)
                prod_q[i] <= (2*bw)'($signed(a[i*bw +: bw])) * (2*bw)'($signed(b[i*bw +: bw]));
        end
    end

    // Heap-indexed tree: node i sums nodes 2i and 2i+1; leaves pr..2pr-1 are the products.
    always_comb begin
        for (int i = 1; i < pr; i++) node_all[i] = node_q[i];
        for (int i = 0; i < pr; i++) node_all[pr+i] = bw_psum'(prod_q[i]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 1; i < pr; i++) node_q[i] <= '0;
        end else begin
            for (int i = 1; i < pr; i++) node_q[i] <= node_all[2*i] + node_all[2*i+1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v_q <= '0;
            f_q <= '0;
            l_q <= '0;
        end else begin
            v_q <= {v_q[lv-1:0], in_valid};
            f_q <= {f_q[lv-1:0], in_valid & in_first};
            l_q <= {l_q[lv-1:0], in_valid & in_last};
        end
    end

    assign tree     = node_all[1];
    assign acc_base = f_q[lv] ? '0 : acc_q;
    assign acc_sum  = acc_base + tree;

`ifdef SATURATE_EN
    localparam logic [bw_psum-1:0] sat_max = {1'b0, {(bw_psum-1){1'b1}}};
    localparam logic [bw_psum-1:0] sat_min = {1'b1, {(bw_psum-1){1'b0}}};
    logic ovf_pos, ovf_neg;

    // A first beat adds onto zero, so it can never overflow and clears any clamp.
    assign ovf_pos = !acc_base[bw_psum-1] && !tree[bw_psum-1] &&  acc_sum[bw_psum-1];
    assign ovf_neg =  acc_base[bw_psum-1] &&  tree[bw_psum-1] && !acc_sum[bw_psum-1];

    always_comb begin
        acc_nxt = acc_sum;
        if (ovf_pos)
            acc_nxt = sat_max;
        else if (ovf_neg)
            acc_nxt = sat_min;
    end
`else
    assign acc_nxt = acc_sum;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q     <= '0;
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= v_q[lv] & l_q[lv];
            if (v_q[lv]) acc_q <= acc_nxt;
            if (v_q[lv] && l_q[lv]) out <= acc_nxt;
        end
    end

endmodule

// File: tb/tb_mac_tree_acc.sv
// Directed bench for mac_tree_acc: pr=8 and pr=64 instances, SATURATE_EN aware.
module tb_mac_tree_acc;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;

    logic        v8 = 0, f8 = 0, l8 = 0;
    logic [63:0] a8 = '0, b8 = '0;
    logic [21:0] out8;
    logic        ov8;

    logic         v64 = 0, f64 = 0, l64 = 0;
    logic [511:0] a64 = '0, b64 = '0;
    logic [21:0]  out64;
    logic         ov64;

    int checks = 0;
    int failures = 0;

    logic        exp_v [0:63];
    logic [21:0] exp_o [0:63];
    logic [21:0] acc_m;
    logic [21:0] exp_sat;
    int          dot;
    int          glen;
    int          seen;
    int          n_rand;

    always #5 clk = ~clk;

    mac_tree_acc #(.bw(8), .pr(8), .bw_psum(22)) dut8 (
        .clk(clk), .reset_n(reset_n), .in_valid(v8), .in_first(f8), .in_last(l8),
        .a(a8), .b(b8), .out(out8), .out_valid(ov8)
    );

    mac_tree_acc #(.bw(8), .pr(64), .bw_psum(22)) dut64 (
        .clk(clk), .reset_n(reset_n), .in_valid(v64), .in_first(f64), .in_last(l64),
        .a(a64), .b(b64), .out(out64), .out_valid(ov64)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] rep8(input logic [7:0] x);
        return {8{x}};
    endfunction

    task automatic beat8(input logic f, input logic l, input logic [63:0] av, input logic [63:0] bv);
        v8 = 1'b1; f8 = f; l8 = l; a8 = av; b8 = bv;
        step();
        v8 = 1'b0; f8 = 1'b0; l8 = 1'b0;
    endtask

    task automatic wait_out(input string tag, input logic [21:0] expv);
        int n;
        n = 0;
        while (!ov8 && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_valid"}, ov8, 1);
        chk(tag, out8, expv);
    endtask

    initial begin
        // reset state
        step();
        step();
        chk("rst_out8", out8, 0);
        chk("rst_ov8", ov8, 0);
        chk("rst_out64", out64, 0);
        chk("rst_ov64", ov64, 0);
        reset_n = 1'b1;
        step();

        // single beat latency and pulse width
        beat8(1, 1, rep8(8'd1), rep8(8'd2));
        chk("lat_e0", ov8, 0);
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("lat_early", ov8, 0);
        end
        step();
        chk("lat_pulse", ov8, 1);
        chk("lat_out", out8, 16);
        step();
        chk("lat_width", ov8, 0);
        chk("lat_hold", out8, 16);

        // signed extremes
        beat8(1, 1, rep8(8'h80), rep8(8'h80));
        wait_out("neg_neg", 22'd131072);
        beat8(1, 1, rep8(8'h80), rep8(8'h7F));
        wait_out("neg_pos", 22'h3E0400);
        beat8(1, 1, 64'h01FF01FF01FF01FF, rep8(8'd5));
        wait_out("mixed", 22'd0);

        // groups with bubbles (flags asserted without valid must be ignored)
        beat8(1, 0, rep8(8'd1), rep8(8'd1));
        f8 = 1'b1; l8 = 1'b1;
        step();
        step();
        beat8(0, 0, rep8(8'd1), rep8(8'd1));
        f8 = 1'b1; l8 = 1'b1;
        step();
        step();
        beat8(0, 1, rep8(8'd1), rep8(8'd1));
        beat8(1, 1, rep8(8'd2), rep8(8'd3));
        for (int i = 0; i < 2; i++) begin
            step();
            chk("b2b_quiet", ov8, 0);
        end
        step();
        chk("grp3_valid", ov8, 1);
        chk("grp3_out", out8, 24);
        step();
        chk("b2b_valid", ov8, 1);
        chk("b2b_out", out8, 48);
        step();
        chk("b2b_end", ov8, 0);
        chk("b2b_hold", out8, 48);

        // overflow over 32 beats
        for (int i = 0; i < 32; i++)
            beat8(i == 0, i == 31, rep8(8'h80), rep8(8'h80));
`ifdef SATURATE_EN
        exp_sat = 22'd2097151;
`else
        exp_sat = 22'd0;
`endif
        wait_out("ovf32", exp_sat);
        beat8(1, 1, rep8(8'd1), rep8(8'd1));
        wait_out("after_ovf", 22'd8);

        // asynchronous reset with three beats in flight
        beat8(1, 0, rep8(8'd3), rep8(8'd3));
        beat8(0, 0, rep8(8'd3), rep8(8'd3));
        beat8(0, 1, rep8(8'd3), rep8(8'd3));
        reset_n = 1'b0;
        #1;
        chk("arst_out", out8, 0);
        chk("arst_ov", ov8, 0);
        step();
        step();
        reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (ov8) seen++;
        end
        chk("no_stale", seen, 0);
        beat8(1, 1, rep8(8'd1), rep8(8'd1));
        wait_out("post_rst", 22'd8);

        // pr=64 latency
        v64 = 1'b1; f64 = 1'b1; l64 = 1'b1; a64 = {64{8'h01}}; b64 = {64{8'h01}};
        step();
        v64 = 1'b0; f64 = 1'b0; l64 = 1'b0;
        chk("l64_e0", ov64, 0);
        for (int i = 1; i <= 6; i++) begin
            step();
            chk("l64_early", ov64, 0);
        end
        step();
        chk("l64_valid", ov64, 1);
        chk("l64_out", out64, 64);
        step();
        chk("l64_width", ov64, 0);

        // pr=64 random stream at full rate against a reference model
        for (int i = 0; i < 64; i++) begin
            exp_v[i] = 1'b0;
            exp_o[i] = '0;
        end
        acc_m = '0;
        glen = 0;
        n_rand = 40;
        for (int t = 0; t < n_rand + 8; t++) begin
            if (t < n_rand && $urandom_range(0, 3) != 0) begin
                for (int j = 0; j < 16; j++) begin
                    a64[32*j +: 32] = $urandom;
                    b64[32*j +: 32] = $urandom;
                end
                v64 = 1'b1;
                f64 = (glen == 0);
                glen++;
                l64 = (glen == 3) || ($urandom_range(0, 1) == 1);
                if (l64) glen = 0;
                dot = 0;
                for (int i = 0; i < 64; i++) begin
                    byte sa, sb;
                    sa = a64[8*i +: 8];
                    sb = b64[8*i +: 8];
                    dot += sa * sb;
                end
                acc_m = f64 ? 22'(dot) : acc_m + 22'(dot);
                if (l64) begin
                    exp_v[t+7] = 1'b1;
                    exp_o[t+7] = acc_m;
                end
            end else begin
                v64 = 1'b0;
                f64 = 1'($urandom_range(0, 1));
                l64 = 1'($urandom_range(0, 1));
            end
            step();
            chk("rnd_valid", ov64, exp_v[t]);
            if (exp_v[t]) chk("rnd_out", out64, exp_o[t]);
        end
        v64 = 1'b0; f64 = 1'b0; l64 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mac_tree_acc.md
Name: mac_tree_acc

Overview:
Parametrised, fully pipelined signed dot-product engine with group accumulation, successor to the fixed 8-lane MAC.
- Multiplies pr signed bw-bit lane pairs, reduces them through a registered binary adder tree, and accumulates across multi-beat groups marked by first/last flags.
- Streaming datapath: one beat accepted per cycle, no backpressure. Feeds the psum/ofifo path of the core.

Parameters:
bw, 8, lane operand width (signed two's complement)
pr, 8, lane count; power of 2, range 2..64
bw_psum, 2*bw+6, accumulator/output width; must be >= 2*bw+log2(pr)

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  beat valid
in_first  input  1  beat starts a new group (qualified by in_valid)
in_last  input  1  beat ends a group (qualified by in_valid)
a  input  pr*bw  lane operands, lane i = a[bw*(i+1)-1:bw*i]
b  input  pr*bw  lane operands, same packing
out  output  bw_psum  group result, signed
out_valid  output  1  one-cycle pulse, out holds a new group result

Behaviour:
- Reset (reset_n low, async): all product, tree, valid/flag pipeline, accumulator, out and out_valid registers go to 0. In-flight beats are discarded. Reset mid-group drops the partial group with no output.
- Stage P: for each lane, register the signed 2*bw product (operands sign-extended).
- Tree: log2(pr) registered levels. Each level sign-extends to bw_psum and adds pairs. The tree cannot overflow given the bw_psum constraint.
- Accumulator register: on a valid tree result, acc <= first ? tree : acc + tree, mod 2^bw_psum.
- in_valid, in_first and in_last travel in a valid pipeline aligned with the data. Bubbles (in_valid=0) propagate. acc holds during bubbles, so bubbles inside a group do not change the result.
- LAT = log2(pr)+2 cycles.
  - A beat sampled at edge k with in_last=1 drives out_valid=1 and out=final acc in the cycle after edge k+LAT-1.
  - Example: pr=8 gives LAT=5.
- out_valid is high for exactly one cycle per last beat. out holds the last result until the next out_valid. Intermediate acc values are not visible on out.
- in_first=in_last=1: single-beat group; out = that beat's dot product.
- Valid beat with in_first=0 and no open group (e.g. after reset): accumulates onto the current acc, which is 0 after reset.
- in_first arriving while a group is open: the old partial is discarded and a new group starts.
- in_first/in_last are ignored when in_valid=0.
- Back-to-back groups at full rate: last beat of group n followed next cycle by first beat of group n+1 gives out_valid on two consecutive cycles with independent results.

Optional Feature:
SATURATE_EN
- Defined: the accumulator add saturates to the signed range [-2^(bw_psum-1), 2^(bw_psum-1)-1]. Overflow is detected from operand and result signs. Once saturated, acc stays clamped for further same-sign adds. in_first clears the saturation.
- Undefined: the add wraps mod 2^bw_psum. No saturation logic.
- Tree and product behaviour are identical in both builds.

Test Plan:
1. pr=8, bw=8, bw_psum=22. One beat first=last=1, all a=1, b=2 -> out=16, out_valid pulse 5 cycles after the sampling edge, exactly 1 cycle wide.
2. Signed extremes, single beats:
   - a=b=0x80 all lanes -> out=131072.
   - a=0x80, b=0x7F -> out=0x3E0400 (-130048).
   - Mixed lanes: a=-1,+1 alternating, b=5 -> out=0.
3. Groups and bubbles:
   - 3-beat group (first, mid, last), all a=b=1, with 2 bubble cycles between beats -> out=24.
   - Immediately after, single beat a=2, b=3 -> out=48 on the next cycle. out_valid high on both consecutive cycles.
4. Overflow, 32 beats a=b=0x80 in one group:
   - Without SATURATE_EN -> out=0 (wrap of 2^22).
   - With SATURATE_EN -> out=2097151.
   - Then a new group with first=last=1 and a=b=1 -> out=8.
5. reset_n pulsed low asynchronously mid-group, with 3 beats in flight -> out=0 and out_valid=0 immediately, no stale pulse after release. A new single beat a=b=1 then gives out=8 at normal latency.
6. pr=64, bw_psum=22. Single beat a=b=1 -> out=64 with LAT=8. Random vectors checked against a reference model at full rate.
